// File: rtl/rapids_pkg.sv
// Shared types and constants for the instruction prefetch path.
package rapids_pkg;

    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_INSTR_W = 32;
    localparam int PC_STEP     = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [DEF_INSTR_W-1:0] instr;
        logic [DEF_ADDR_W-1:0]  pc;
        logic                   fault;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of fetched entries; head is presented combinationally, zero when empty.
module fetch_fifo
    import rapids_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fetch_entry_t,
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int CNT_W   = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  entry_t           wr_data,
    output entry_t           rd_data,
    output logic [CNT_W-1:0] count,
    output logic             full
);

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             empty;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    // No full bypass: a push is refused at DEPTH even when the head leaves.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

    always_comb begin
        rd_data = '0;
        if (!empty) rd_data = mem[rd_ptr];
    end

endmodule

// File: rtl/fetch_queue.sv
// Prefetch stage: owns the fetch PC, talks to the MMU instruction port, and
// feeds a small queue of {instr, pc, fault} entries to the controlpath.
module fetch_queue
    import rapids_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter int                INSTR_W  = DEF_INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    localparam int               CNT_W    = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic [ADDR_W-1:0]  mmu_addr,
    input  logic [INSTR_W-1:0] mmu_instr,
    input  logic               mmu_wait,
    input  logic               mmu_segv,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_fault,
    output logic               instr_valid,
    input  logic               instr_take,
    output logic [CNT_W-1:0]   count
);

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
        logic               fault;
    } entry_t;

    fetch_state_t      state;
    logic [ADDR_W-1:0] pc;
    entry_t            wr_entry;
    entry_t            head;
    logic              full;
    logic              accept;
    logic              pop;

    assign accept = (state == FETCH) && run && !redirect && !mmu_wait && !full;
    // A redirect flushes the queue, so a same-cycle take has nothing to remove.
    assign pop    = instr_take && !redirect;

    always_comb begin
        wr_entry.instr = mmu_segv ? '0 : mmu_instr;
        wr_entry.pc    = pc;
        wr_entry.fault = mmu_segv;
    end

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (accept),
        .pop     (pop),
        .flush   (redirect),
        .wr_data (wr_entry),
        .rd_data (head),
        .count   (count),
        .full    (full)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            pc    <= RESET_PC;
        end else if (redirect) begin
            pc    <= {redirect_pc[ADDR_W-1:2], 2'b00};
            state <= run ? FETCH : IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (run) state <= FETCH;
                end
                FETCH: begin
                    if (!run) begin
                        state <= IDLE;
                    end else if (accept) begin
                        // A faulting address is held so the PC still names it.
                        if (mmu_segv) state <= FAULT;
                        else          pc    <= pc + ADDR_W'(PC_STEP);
                    end
                end
                FAULT:   state <= FAULT;
                default: state <= IDLE;
            endcase
        end
    end

    assign mmu_addr    = pc;
    assign instr       = head.instr;
    assign instr_pc    = head.pc;
    assign instr_fault = head.fault;
    assign instr_valid = (count != '0);

endmodule
